i2s_rx: RTL and testbench

Serial-to-parallel I2S receiver. It recovers stereo PCM samples from an external I2S source (ADC or codec line-in) into the `clk32` system domain. It is the receive counterpart of the top-level I2S DAC feed. It delivers `WIDTH`-bit left/right words plus a one-cycle frame strobe to the audio mixer, and flags lock state so downstream logic can mute on loss of signal.

---
 rtl/audio_pkg.sv | 11 +
 rtl/i2s_rx_sync.sv | 31 +++
 rtl/i2s_rx.sv | 134 +++++++++++++
 tb/tb_i2s_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and the I2S receiver state type.
package audio_pkg;
  localparam int AUDIO_WIDTH = 16;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    CHECK  = 2'd2,
    RUN    = 2'd3
  } i2s_rx_state_t;
endpackage

// File: rtl/i2s_rx_sync.sv
// Two-flop synchronizers for bclk/lrck/din plus a third bclk flop for rising-edge detect.
module i2s_rx_sync (
  input  logic clk32,
  input  logic reset_n,
  input  logic i2s_bclk,
  input  logic i2s_lrck,
  input  logic i2s_din,
  output logic lrck_s,
  output logic din_s,
  output logic samp
);
  logic [2:0] bclk_q;
  logic [1:0] lrck_q;
  logic [1:0] din_q;

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      bclk_q <= '0;
      lrck_q <= '0;
      din_q  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], i2s_bclk};
      lrck_q <= {lrck_q[0], i2s_lrck};
      din_q  <= {din_q[0], i2s_din};
    end
  end

  assign samp   = bclk_q[1] & ~bclk_q[2];
  assign lrck_s = lrck_q[1];
  assign din_s  = din_q[1];
endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises stereo words, checks frame-length consistency and
// strobes left/right pairs into the clk32 domain once the stream is locked.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int WIDTH     = AUDIO_WIDTH,
  parameter int I2S_DELAY = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk32,
  input  logic             reset_n,
  input  logic             i2s_bclk,
  input  logic             i2s_lrck,
  input  logic             i2s_din,
  output logic [WIDTH-1:0] audio_l,
  output logic [WIDTH-1:0] audio_r,
  output logic             sample_valid,
  output logic             locked
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic lrck_s, din_s, samp;

  i2s_rx_sync u_sync (
    .clk32    (clk32),
    .reset_n  (reset_n),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .i2s_din  (i2s_din),
    .lrck_s   (lrck_s),
    .din_s    (din_s),
    .samp     (samp)
  );

  i2s_rx_state_t    state, state_next;
  logic             lrck_prev;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg, stage_l;
  logic [7:0]       frame_bits, ref_len;
  logic [IW-1:0]    idle_cnt;

  logic             boundary, fall, timeout, close_l, close_r;
  logic [WIDTH-1:0] msb_bit, shreg_in, word;

  assign boundary = samp && (lrck_s != lrck_prev);
  assign fall     = boundary && lrck_prev && !lrck_s;
  assign timeout  = (idle_cnt == IW'(TIMEOUT));
  assign close_l  = boundary && !lrck_prev && (state != SEARCH);
  assign close_r  = fall && (state != SEARCH);
  assign msb_bit  = {din_s, {(WIDTH-1){1'b0}}};

  // Bits land directly at their final position, so short words come out
  // left-aligned and zero-filled without a separate alignment step.
  always_comb begin
    shreg_in = shreg;
    if (bitcnt < CW'(WIDTH)) shreg_in = shreg | (msb_bit >> bitcnt);
    word = (I2S_DELAY != 0) ? shreg_in : shreg;
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      lrck_prev  <= 1'b0;
      bitcnt     <= '0;
      shreg      <= '0;
      frame_bits <= '0;
      idle_cnt   <= '0;
    end else begin
      if (samp) begin
        lrck_prev <= lrck_s;
        idle_cnt  <= '0;
        if (fall) frame_bits <= 8'd1;
        else if (frame_bits != 8'd255) frame_bits <= frame_bits + 8'd1;
        if (boundary) begin
          if (I2S_DELAY != 0) begin
            shreg  <= '0;
            bitcnt <= '0;
          end else begin
            shreg  <= msb_bit;
            bitcnt <= CW'(1);
          end
        end else if (bitcnt < CW'(WIDTH)) begin
          shreg  <= shreg_in;
          bitcnt <= bitcnt + CW'(1);
        end
      end else if (!timeout) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      stage_l      <= '0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
      ref_len      <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (close_l) stage_l <= word;
      if (close_r) begin
        audio_l      <= stage_l;
        audio_r      <= word;
        sample_valid <= (state_next == RUN);
      end
      if (fall && (state == SYNC || state == CHECK)) ref_len <= frame_bits;
    end
  end

  always_ff @(posedge clk32) begin
    if (!reset_n) state <= SEARCH;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = SEARCH;
    end else if (fall) begin
      case (state)
        SEARCH:  state_next = SYNC;
        SYNC:    state_next = CHECK;
        CHECK:   if (frame_bits == ref_len) state_next = RUN;
        RUN:     if (frame_bits != ref_len) state_next = SYNC;
        default: state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == RUN);
  end
endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench: random stereo streams in Philips and left-justified
// formats compared against a frame-level model of expected strobes.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int W  = 16;
  localparam int TO = 255;

  logic clk32 = 1'b0, reset_n = 1'b0, bclk = 1'b0, lrck = 1'b0, din = 1'b0;
  logic [W-1:0] al1, ar1, al0, ar0;
  logic sv1, sv0, lk1, lk0;

  always #15.625 clk32 = ~clk32;

  i2s_rx #(.WIDTH(W), .I2S_DELAY(1), .TIMEOUT(TO)) dut_ph (
    .clk32(clk32), .reset_n(reset_n), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_din(din),
    .audio_l(al1), .audio_r(ar1), .sample_valid(sv1), .locked(lk1));

  i2s_rx #(.WIDTH(W), .I2S_DELAY(0), .TIMEOUT(TO)) dut_lj (
    .clk32(clk32), .reset_n(reset_n), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_din(din),
    .audio_l(al0), .audio_r(ar0), .sample_valid(sv0), .locked(lk0));

  int checks = 0, fails = 0;
  int bit_idx = 0;
  bit sch[$], sdt[$];

  // Strobe logs and pulse/lock bookkeeping, sampled on the falling clk edge.
  logic [W-1:0] ql1[$], qr1[$], ql0[$], qr0[$];
  int long_pulses = 0, lock_falls = 0;
  logic sv1_d = 1'b0, sv0_d = 1'b0, lk1_d = 1'b0;
  always @(negedge clk32) begin
    if (sv1) begin ql1.push_back(al1); qr1.push_back(ar1); end
    if (sv0) begin ql0.push_back(al0); qr0.push_back(ar0); end
    if ((sv1 && sv1_d) || (sv0 && sv0_d)) long_pulses++;
    if (lk1_d && !lk1) lock_falls++;
    sv1_d = sv1; sv0_d = sv0; lk1_d = lk1;
  end

  // Model: a slot of 'slot' bits delivers its top W bits, or is zero-extended on the right.
  function automatic logic [W-1:0] exp_word(input logic [31:0] d, input int slot);
    logic [31:0] t;
    if (slot >= W) t = d >> (slot - W);
    else           t = d << (W - slot);
    return t[W-1:0];
  endfunction

  task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int slot);
    for (int i = slot - 1; i >= 0; i--) begin sch.push_back(1'b0); sdt.push_back(l[i]); end
    for (int i = slot - 1; i >= 0; i--) begin sch.push_back(1'b1); sdt.push_back(r[i]); end
  endtask

  // Plays the queued bits at clk32/20; a trailing left bit closes the last frame in either format.
  task automatic drive(input bit philips);
    sch.push_back(1'b0); sdt.push_back(1'b0);
    for (int k = 0; k < sch.size(); k++) begin
      bit_idx = k;
      @(negedge clk32); #3;
      bclk = 1'b0;
      lrck = philips ? ((k + 1 < sch.size()) ? sch[k+1] : 1'b0) : sch[k];
      din  = sdt[k];
      repeat (10) @(negedge clk32);
      #3 bclk = 1'b1;
      repeat (9) @(negedge clk32);
    end
    @(negedge clk32); #3 bclk = 1'b0;
    sch.delete(); sdt.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk32); reset_n = 1'b0;
    repeat (2) @(negedge clk32);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk32);
    checks++; if (al1 !== '0)   begin fails++; $display("FAIL reset_audio_l: got %h expected 0000", al1); end
    checks++; if (ar1 !== '0)   begin fails++; $display("FAIL reset_audio_r: got %h expected 0000", ar1); end
    checks++; if (sv1 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", sv1); end
    checks++; if (lk1 !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b expected 0", lk1); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int b = ql1.size(); int lp = long_pulses;
    apply_reset();
    for (int f = 0; f < 6; f++) add_frame(32'h1234, 32'hABCD, 16);
    drive(1'b1);
    checks++; if (ql1.size() - b != 4) begin fails++; $display("FAIL basic_count: got %0d expected 4", ql1.size() - b); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (ql1[b+i] !== 16'h1234 || qr1[b+i] !== 16'hABCD) begin
        fails++; $display("FAIL basic_word%0d: got %h/%h expected 1234/abcd", i, ql1[b+i], qr1[b+i]); end
    end
    checks++; if (lk1 !== 1'b1) begin fails++; $display("FAIL basic_locked: got %b expected 1", lk1); end
    checks++; if (long_pulses != lp) begin fails++; $display("FAIL basic_pulse_width: got %0d long pulses expected 0", long_pulses - lp); end
  endtask

  task automatic test_random_philips();
    int b = ql1.size(); logic [W-1:0] el[$], er[$]; logic [31:0] l, r;
    apply_reset();
    for (int f = 0; f < 7; f++) begin
      l = $urandom; r = $urandom; add_frame(l, r, 16);
      if (f >= 2) begin el.push_back(exp_word(l, 16)); er.push_back(exp_word(r, 16)); end
    end
    drive(1'b1);
    checks++; if (ql1.size() - b != el.size()) begin fails++; $display("FAIL rand_count: got %0d expected %0d", ql1.size() - b, el.size()); end
    else for (int i = 0; i < el.size(); i++) begin
      checks++; if (ql1[b+i] !== el[i] || qr1[b+i] !== er[i]) begin
        fails++; $display("FAIL rand_word%0d: got %h/%h expected %h/%h", i, ql1[b+i], qr1[b+i], el[i], er[i]); end
    end
  endtask

  task automatic test_left_justified();
    int b = ql0.size(); logic [W-1:0] el[$], er[$]; logic [31:0] l, r;
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      l = (f % 2 == 0) ? 32'h1234 : $urandom; r = (f % 2 == 0) ? 32'hABCD : $urandom;
      add_frame(l, r, 16);
      if (f >= 2) begin el.push_back(exp_word(l, 16)); er.push_back(exp_word(r, 16)); end
    end
    drive(1'b0);
    checks++; if (ql0.size() - b != el.size()) begin fails++; $display("FAIL lj_count: got %0d expected %0d", ql0.size() - b, el.size()); end
    else for (int i = 0; i < el.size(); i++) begin
      checks++; if (ql0[b+i] !== el[i] || qr0[b+i] !== er[i]) begin
        fails++; $display("FAIL lj_word%0d: got %h/%h expected %h/%h", i, ql0[b+i], qr0[b+i], el[i], er[i]); end
    end
    checks++; if (lk0 !== 1'b1) begin fails++; $display("FAIL lj_locked: got %b expected 1", lk0); end
  endtask

  task automatic test_slots();
    int b; logic [W-1:0] er[$]; logic [31:0] r;
    apply_reset(); b = ql1.size();
    for (int f = 0; f < 5; f++) begin
      r = $urandom; add_frame(32'h8001_FFFF, r, 32);
      if (f >= 2) er.push_back(exp_word(r, 32));
    end
    drive(1'b1);
    checks++; if (ql1.size() - b != 3) begin fails++; $display("FAIL long_count: got %0d expected 3", ql1.size() - b); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (ql1[b+i] !== 16'h8001 || qr1[b+i] !== er[i]) begin
        fails++; $display("FAIL long_word%0d: got %h/%h expected 8001/%h", i, ql1[b+i], qr1[b+i], er[i]); end
    end
    er.delete();
    apply_reset(); b = ql1.size();
    for (int f = 0; f < 5; f++) begin
      r = $urandom; add_frame(32'hFFF, r, 12);
      if (f >= 2) er.push_back(exp_word(r, 12));
    end
    drive(1'b1);
    checks++; if (ql1.size() - b != 3) begin fails++; $display("FAIL short_count: got %0d expected 3", ql1.size() - b); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (ql1[b+i] !== 16'hFFF0 || qr1[b+i] !== er[i]) begin
        fails++; $display("FAIL short_word%0d: got %h/%h expected fff0/%h", i, ql1[b+i], qr1[b+i], er[i]); end
    end
  endtask

  task automatic test_loss_of_bclk();
    int b, n; logic [W-1:0] el[$], er[$]; logic [31:0] l, r;
    apply_reset(); b = ql1.size();
    for (int f = 0; f < 5; f++) begin
      l = $urandom; r = $urandom; add_frame(l, r, 16);
      if (f >= 2) begin el.push_back(exp_word(l, 16)); er.push_back(exp_word(r, 16)); end
    end
    drive(1'b1);
    checks++; if (ql1.size() - b != 3) begin fails++; $display("FAIL loss_pre_count: got %0d expected 3", ql1.size() - b); end
    checks++; if (lk1 !== 1'b1) begin fails++; $display("FAIL loss_pre_locked: got %b expected 1", lk1); end
    // drive() returns 10 clk32 cycles after the last bclk rise
    n = 10;
    while (lk1 !== 1'b0 && n < 400) begin @(negedge clk32); n++; end
    checks++; if (n < TO + 2 || n > TO + 6) begin fails++; $display("FAIL loss_drop_cycle: got %0d expected %0d..%0d", n, TO + 2, TO + 6); end
    checks++; if (al1 !== el[2] || ar1 !== er[2]) begin
      fails++; $display("FAIL loss_hold: got %h/%h expected %h/%h", al1, ar1, el[2], er[2]); end
    if (n < 300) repeat (300 - n) @(negedge clk32);
    el.delete(); er.delete(); b = ql1.size();
    for (int f = 0; f < 5; f++) begin
      l = $urandom; r = $urandom; add_frame(l, r, 16);
      if (f >= 2) begin el.push_back(exp_word(l, 16)); er.push_back(exp_word(r, 16)); end
    end
    drive(1'b1);
    checks++; if (ql1.size() - b != 3) begin fails++; $display("FAIL loss_post_count: got %0d expected 3", ql1.size() - b); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (ql1[b+i] !== el[i] || qr1[b+i] !== er[i]) begin
        fails++; $display("FAIL loss_post_word%0d: got %h/%h expected %h/%h", i, ql1[b+i], qr1[b+i], el[i], er[i]); end
    end
    checks++; if (lk1 !== 1'b1) begin fails++; $display("FAIL loss_relock: got %b expected 1", lk1); end
  endtask

  task automatic test_length_change();
    int b, lf; logic [W-1:0] el[$], er[$]; logic [31:0] l, r;
    apply_reset(); b = ql1.size(); lf = lock_falls;
    for (int f = 0; f < 10; f++) begin
      l = $urandom; r = $urandom; add_frame(l, r, (f < 5) ? 16 : 24);
      // frame 5 breaks the length, frames 6 and 7 re-measure it
      if ((f >= 2 && f < 5) || f >= 7) begin
        el.push_back(exp_word(l, (f < 5) ? 16 : 24)); er.push_back(exp_word(r, (f < 5) ? 16 : 24));
      end
    end
    drive(1'b1);
    checks++; if (lock_falls - lf != 1) begin fails++; $display("FAIL change_lock_drops: got %0d expected 1", lock_falls - lf); end
    checks++; if (ql1.size() - b != el.size()) begin fails++; $display("FAIL change_count: got %0d expected %0d", ql1.size() - b, el.size()); end
    else for (int i = 0; i < el.size(); i++) begin
      checks++; if (ql1[b+i] !== el[i] || qr1[b+i] !== er[i]) begin
        fails++; $display("FAIL change_word%0d: got %h/%h expected %h/%h", i, ql1[b+i], qr1[b+i], el[i], er[i]); end
    end
    checks++; if (lk1 !== 1'b1) begin fails++; $display("FAIL change_relock: got %b expected 1", lk1); end
  endtask

  task automatic test_reset_mid_frame();
    int b, g; logic [W-1:0] el[$], er[$]; logic [31:0] l, r;
    apply_reset(); b = ql1.size();
    for (int f = 0; f < 9; f++) begin
      l = $urandom; r = $urandom; add_frame(l, r, 16);
      if (f == 2 || f == 3 || f >= 6) begin el.push_back(exp_word(l, 16)); er.push_back(exp_word(r, 16)); end
    end
    fork
      drive(1'b1);
      begin
        g = 0;
        while (bit_idx < 4 * 32 + 8 && g < 20000) begin @(negedge clk32); g++; end
        checks++; if (g >= 20000) begin fails++; $display("FAIL mid_reset_wait: got timeout expected bit %0d", 4 * 32 + 8); end
        repeat (3) @(negedge clk32);
        reset_n = 1'b0;
        @(negedge clk32);
        checks++; if (al1 !== '0 || ar1 !== '0 || sv1 !== 1'b0 || lk1 !== 1'b0) begin
          fails++; $display("FAIL mid_reset_outputs: got %h/%h v%b l%b expected 0000/0000 v0 l0", al1, ar1, sv1, lk1); end
        reset_n = 1'b1;
      end
    join
    checks++; if (ql1.size() - b != el.size()) begin fails++; $display("FAIL mid_reset_count: got %0d expected %0d", ql1.size() - b, el.size()); end
    else for (int i = 0; i < el.size(); i++) begin
      checks++; if (ql1[b+i] !== el[i] || qr1[b+i] !== er[i]) begin
        fails++; $display("FAIL mid_reset_word%0d: got %h/%h expected %h/%h", i, ql1[b+i], qr1[b+i], el[i], er[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_philips();
    test_left_justified();
    test_slots();
    test_loss_of_bclk();
    test_length_change();
    test_reset_mid_frame();
    checks++; if (long_pulses != 0) begin fails++; $display("FAIL strobe_width: got %0d long pulses expected 0", long_pulses); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
